// File: rtl/dcpu16_arb_pkg.sv
// Shared definitions for the DCPU16 memory-bus arbiter: FSM state encoding and priority modes.
package dcpu16_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

endpackage

// File: rtl/dcpu16_arb_pick.sv
// Combinational NCH-wide priority picker: lowest index wins, or search starting at ptr when mode=1.
module dcpu16_arb_pick
  import dcpu16_arb_pkg::*;
#(
  parameter int NCH = 2,
  parameter int PW  = 1
) (
  input  logic [NCH-1:0] req,
  input  logic [PW-1:0]  ptr,
  input  logic           mode,
  output logic [NCH-1:0] pick
);

  logic [PW-1:0]    sh;
  logic [2*NCH-1:0] dbl_req;
  logic [2*NCH-1:0] dbl_oh;
  logic [NCH-1:0]   rot_req;
  logic [NCH-1:0]   rot_oh;
  logic             found;

  // Rotate requests so the search start sits at bit 0, pick the first one, rotate back.
  always_comb begin
    sh      = mode ? ptr : '0;
    dbl_req = {req, req} >> sh;
    rot_req = dbl_req[NCH-1:0];
    rot_oh  = '0;
    found   = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (!found && rot_req[k]) begin
        rot_oh[k] = 1'b1;
        found     = 1'b1;
      end
    end
    dbl_oh = {rot_oh, rot_oh} << sh;
    pick   = dbl_oh[2*NCH-1:NCH];
  end

endmodule

// File: rtl/dcpu16_arb.sv
// N-channel single-beat memory-bus arbiter with registered one-hot grant.
// Optional busy timeout enabled by defining DCPU16_ARB_TIMEOUT_EN.
module dcpu16_arb
  import dcpu16_arb_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int AW    = 16,
  parameter int DW    = 16,
  parameter int MODE  = 0,
  parameter int TOCNT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    m_stb,
  input  logic [NCH-1:0]    m_wre,
  input  logic [NCH*AW-1:0] m_adr,
  input  logic [NCH*DW-1:0] m_dto,
  output logic [NCH-1:0]    m_ack,
  output logic [NCH-1:0]    m_err,
  output logic [DW-1:0]     m_dti,
  output logic              s_stb,
  output logic              s_wre,
  output logic [AW-1:0]     s_adr,
  output logic [DW-1:0]     s_dto,
  input  logic              s_ack,
  input  logic [DW-1:0]     s_dti,
  output logic [NCH-1:0]    gnt
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  if (NCH < 2 || NCH > 8 || TOCNT < 1 || TOCNT > 65535) begin : g_param_check
    $error("dcpu16_arb: NCH or TOCNT out of range");
  end

  arb_state_t     state, state_nxt;
  logic [NCH-1:0] gnt_nxt;
  logic [PW-1:0]  ptr, ptr_nxt;
  logic [PW-1:0]  pidx;
  logic [NCH-1:0] pick;
  logic           busy;
  logic           to_fire;

  assign busy = (state == ARB_BUSY);

  dcpu16_arb_pick #(
    .NCH (NCH),
    .PW  (PW)
  ) u_pick (
    .req  (m_stb),
    .ptr  (ptr),
    .mode (MODE == ARB_RR),
    .pick (pick)
  );

  always_comb begin
    pidx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (pick[i]) pidx = PW'(i);
    end
  end

  // Slave-side mux; the grant is one-hot so at most one channel drives.
  always_comb begin
    s_stb = 1'b0;
    s_wre = 1'b0;
    s_adr = '0;
    s_dto = '0;
    for (int i = 0; i < NCH; i++) begin
      if (busy && gnt[i]) begin
        s_stb = m_stb[i];
        s_wre = m_wre[i];
        s_adr = m_adr[i*AW +: AW];
        s_dto = m_dto[i*DW +: DW];
      end
    end
  end

  assign m_ack = gnt & {NCH{busy & s_stb & s_ack}};
  assign m_err = gnt & {NCH{to_fire}};
  assign m_dti = s_dti;

`ifdef DCPU16_ARB_TIMEOUT_EN
  logic [15:0] tocnt, tocnt_nxt;

  // s_ack on the final cycle wins over the timeout.
  assign to_fire = busy & s_stb & ~s_ack & (tocnt == 16'(TOCNT - 1));

  always_comb begin
    tocnt_nxt = tocnt;
    if (!busy && (|m_stb)) tocnt_nxt = '0;
    else if (busy)         tocnt_nxt = tocnt + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tocnt <= '0;
    else     tocnt <= tocnt_nxt;
  end
`else
  assign to_fire = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    ptr_nxt   = ptr;
    case (state)
      ARB_IDLE: begin
        if (|m_stb) begin
          state_nxt = ARB_BUSY;
          gnt_nxt   = pick;
          ptr_nxt   = (pidx == PW'(NCH - 1)) ? '0 : pidx + 1'b1;
        end
      end
      ARB_BUSY: begin
        // A dropped strobe aborts the beat; s_ack is meaningless without it.
        if ((s_stb && s_ack) || !s_stb || to_fire) begin
          state_nxt = ARB_IDLE;
          gnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ARB_IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
      gnt   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      ptr   <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_dcpu16_arb.sv
// Scoreboard bench: a 2-channel fixed-priority arbiter and a 4-channel round-robin arbiter.
module tb_dcpu16_arb;

  typedef struct {
    int          ch;
    bit          err;
    logic [15:0] dti;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [1:0]  stb2 = '0, wre2 = '0, ack2, err2, gnt2;
  logic [31:0] adr2 = '0, dto2 = '0;
  logic [15:0] dti2, s_adr2, s_dto2, s_dti2;
  logic        s_stb2, s_wre2, s_ack2;

  logic [3:0]  stb4 = '0, wre4 = '0, ack4, err4, gnt4;
  logic [63:0] adr4 = '0, dto4 = '0;
  logic [15:0] dti4, s_adr4, s_dto4, s_dti4;
  logic        s_stb4, s_wre4, s_ack4;

  bit slv_en2 = 0, slv_en4 = 0;
  int dly2 = 1, dly4 = 1;

  exp_t q2[$];
  exp_t q4[$];
  int   errors = 0;
  int   checks = 0;
  int   err_at;

  always #5 clk = ~clk;

  dcpu16_arb #(.NCH(2), .AW(16), .DW(16), .MODE(0), .TOCNT(8)) u_dut2 (
    .clk(clk), .rst(rst), .m_stb(stb2), .m_wre(wre2), .m_adr(adr2), .m_dto(dto2),
    .m_ack(ack2), .m_err(err2), .m_dti(dti2), .s_stb(s_stb2), .s_wre(s_wre2),
    .s_adr(s_adr2), .s_dto(s_dto2), .s_ack(s_ack2), .s_dti(s_dti2), .gnt(gnt2)
  );

  dcpu16_arb #(.NCH(4), .AW(16), .DW(16), .MODE(1), .TOCNT(8)) u_dut4 (
    .clk(clk), .rst(rst), .m_stb(stb4), .m_wre(wre4), .m_adr(adr4), .m_dto(dto4),
    .m_ack(ack4), .m_err(err4), .m_dti(dti4), .s_stb(s_stb4), .s_wre(s_wre4),
    .s_adr(s_adr4), .s_dto(s_dto4), .s_ack(s_ack4), .s_dti(s_dti4), .gnt(gnt4)
  );

  function automatic logic [15:0] slv_data(input logic [15:0] a);
    return (a == 16'h1234) ? 16'hBEEF : ~a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push2(input int ch, input bit err, input logic [15:0] d);
    exp_t e;
    e.ch = ch; e.err = err; e.dti = d;
    q2.push_back(e);
  endtask

  task automatic push4(input int ch, input bit err, input logic [15:0] d);
    exp_t e;
    e.ch = ch; e.err = err; e.dti = d;
    q4.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic drain();
    int n = 0;
    while ((q2.size() != 0 || q4.size() != 0) && n < 200) begin
      step();
      n++;
    end
    chk("scoreboard drained", q2.size() + q4.size(), 0);
    q2.delete();
    q4.delete();
  endtask

  // Slave models: ack dly cycles after the strobe is seen, one-cycle pulse.
  initial begin
    int cnt = 0;
    s_ack2 = 1'b0; s_dti2 = '0;
    forever begin
      @(negedge clk);
      if (s_stb2 && slv_en2) begin
        if (cnt >= dly2) begin
          s_ack2 = 1'b1; s_dti2 = slv_data(s_adr2); cnt = 0;
        end else begin
          s_ack2 = 1'b0; cnt++;
        end
      end else begin
        s_ack2 = 1'b0; cnt = 0;
      end
    end
  end

  initial begin
    int cnt = 0;
    s_ack4 = 1'b0; s_dti4 = '0;
    forever begin
      @(negedge clk);
      if (s_stb4 && slv_en4) begin
        if (cnt >= dly4) begin
          s_ack4 = 1'b1; s_dti4 = slv_data(s_adr4); cnt = 0;
        end else begin
          s_ack4 = 1'b0; cnt++;
        end
      end else begin
        s_ack4 = 1'b0; cnt = 0;
      end
    end
  end

  // Monitors: every ack/err pulse must match the head of its queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if ((|ack2) || (|err2)) begin
        if (q2.size() == 0) chk("dut2 unexpected response", {28'd0, ack2, err2}, 0);
        else begin
          e = q2.pop_front();
          chk("dut2 m_ack", {30'd0, ack2}, e.err ? 0 : (1 << e.ch));
          chk("dut2 m_err", {30'd0, err2}, e.err ? (1 << e.ch) : 0);
          if (!e.err) chk("dut2 m_dti", {16'd0, dti2}, {16'd0, e.dti});
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if ((|ack4) || (|err4)) begin
        if (q4.size() == 0) chk("dut4 unexpected response", {24'd0, ack4, err4}, 0);
        else begin
          e = q4.pop_front();
          chk("dut4 m_ack", {28'd0, ack4}, e.err ? 0 : (1 << e.ch));
          chk("dut4 m_err", {28'd0, err4}, e.err ? (1 << e.ch) : 0);
          if (!e.err) chk("dut4 m_dti", {16'd0, dti4}, {16'd0, e.dti});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) step();
    chk("reset gnt2", {30'd0, gnt2}, 0);
    chk("reset gnt4", {28'd0, gnt4}, 0);
    chk("reset s_stb", {30'd0, s_stb2, s_stb4}, 0);
    rst = 1'b0;

    // Reset mid-BUSY with both channels requesting
    adr2 = {16'h0020, 16'h0010};
    step(); stb2 = 2'b11;
    step();
    chk("busy gnt2 before reset", {30'd0, gnt2}, 32'h1);
    chk("busy s_stb2 before reset", {31'd0, s_stb2}, 1);
    step(); rst = 1'b1;
    #1;
    chk("async reset gnt2", {30'd0, gnt2}, 0);
    chk("async reset s_stb2", {31'd0, s_stb2}, 0);
    chk("async reset m_ack2", {30'd0, ack2}, 0);
    stb2 = 2'b00;
    step(); rst = 1'b0;
    step();
    chk("idle after reset gnt2", {30'd0, gnt2}, 0);
    chk("idle after reset s_stb2", {31'd0, s_stb2}, 0);

    // Fixed priority: ch0 always wins while both hold their strobes
    slv_en2 = 1; dly2 = 1;
    repeat (3) push2(0, 0, slv_data(16'h0010));
    stb2 = 2'b11;
    drain();
    stb2 = 2'b00;
    repeat (2) step();

    // Round-robin: 0,1,2,3,0
    slv_en4 = 1; dly4 = 1;
    adr4 = {16'h0103, 16'h0102, 16'h0101, 16'h0100};
    push4(0, 0, slv_data(16'h0100));
    push4(1, 0, slv_data(16'h0101));
    push4(2, 0, slv_data(16'h0102));
    push4(3, 0, slv_data(16'h0103));
    push4(0, 0, slv_data(16'h0100));
    stb4 = 4'b1111;
    drain();
    stb4 = 4'b0000;
    repeat (2) step();

    // Read on ch1 with immediate slave ack
    dly4 = 0;
    adr4[31:16] = 16'h1234;
    push4(1, 0, 16'hBEEF);
    stb4 = 4'b0010;
    step();
    chk("read s_stb one cycle later", {31'd0, s_stb4}, 1);
    chk("read s_adr", {16'd0, s_adr4}, 32'h1234);
    chk("read s_wre", {31'd0, s_wre4}, 0);
    step(); stb4 = 4'b0000;
    drain();
    chk("gnt4 idle after read", {28'd0, gnt4}, 0);

    // Write on ch2
    adr4[47:32] = 16'h00F0; dto4[47:32] = 16'hCAFE; wre4 = 4'b0100;
    push4(2, 0, 16'hFF0F);
    stb4 = 4'b0100;
    step();
    chk("write s_wre", {31'd0, s_wre4}, 1);
    chk("write s_dto", {16'd0, s_dto4}, 32'hCAFE);
    chk("write gnt4", {28'd0, gnt4}, 32'h4);
    step(); stb4 = 4'b0000; wre4 = 4'b0000;
    drain();

    // Abort: ch0 drops its strobe with no slave ack
    slv_en2 = 0;
    stb2 = 2'b01;
    step();
    chk("abort gnt2 while busy", {30'd0, gnt2}, 32'h1);
    stb2 = 2'b00;
    step();
    chk("abort gnt2 after drop", {30'd0, gnt2}, 0);
    chk("abort s_stb2 after drop", {31'd0, s_stb2}, 0);

    // Silent slave: timeout pulse in the 8th busy cycle, or grant held forever
    err_at = 0;
`ifdef DCPU16_ARB_TIMEOUT_EN
    push2(1, 1, 16'h0000);
`endif
    stb2 = 2'b10;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (err2[1] && err_at == 0) err_at = k;
`ifdef DCPU16_ARB_TIMEOUT_EN
      if (k == 9) stb2 = 2'b00;
`endif
    end
`ifdef DCPU16_ARB_TIMEOUT_EN
    chk("timeout busy cycle of m_err", err_at, 8);
    chk("timeout back to idle gnt2", {30'd0, gnt2}, 0);
`else
    chk("no timeout m_err", err_at, 0);
    chk("no timeout grant held", {30'd0, gnt2}, 32'h2);
    stb2 = 2'b00;
    step();
    chk("no timeout idle after drop", {30'd0, gnt2}, 0);
`endif
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
